ex_spi_arb: RTL and testbench
=============================

Name: ex_spi_arb

Overview:
- Parses the MCU SPI byte stream (spi_data/spi_vld from mcuspi_inf) into 4-byte register-write frames.
- Merges those writes with host fx-bus writes onto the single write port of ex_reg.
- Host fx-bus writes always have priority; SPI writes are held in a one-deep buffer until a free slot.
- Reads are host-only and pass straight through.

Parameters:
- TMO_CYC, 1024: clk_sys cycles allowed between consecutive bytes of one frame before the frame is aborted (min 2).
- CMD_WR, 8'hA5: command byte that opens a write frame.

Ports:
- clk_sys  in  1  system clock
- rst  in  1  synchronous reset, active-high
- spi_data  in  8  byte from SPI deserializer
- spi_vld  in  1  1-cycle strobe, spi_data valid
- mcu_sel  in  1  SPI path enable; bytes are ignored while low
- fx_waddr  in  16  host write address
- fx_wr  in  1  host write strobe
- fx_data  in  8  host write data
- fx_rd  in  1  host read strobe
- fx_raddr  in  16  host read address
- fx_q  out  8  host read data
- reg_waddr  out  16  write address to ex_reg
- reg_wr  out  1  write strobe to ex_reg
- reg_data  out  8  write data to ex_reg
- reg_rd  out  1  read strobe to ex_reg
- reg_raddr  out  16  read address to ex_reg
- reg_q  in  8  read data from ex_reg
- stat_clr  in  1  clears spi_err and spi_ovf
- spi_busy  out  1  frame in progress or write pending
- spi_err  out  1  sticky: bad command byte or timeout
- spi_ovf  out  1  sticky: completed frame dropped
- frm_cnt  out  8  count of frames accepted into the buffer

Behaviour:
- Reset (rst=1 at a clk_sys edge) has priority over all other inputs, including mid-frame:
  - FSM goes to S_CMD; pend=0; timer=0.
  - reg_wr=0, reg_waddr=0, reg_data=0.
  - spi_err=0, spi_ovf=0, frm_cnt=0.
- Read path is combinational pass-through with no arbitration: reg_rd=fx_rd, reg_raddr=fx_raddr, fx_q=reg_q.
- A byte counts only when spi_vld=1 and mcu_sel=1. Bytes with mcu_sel=0 cause no state change; the timer keeps running.
- Parser FSM:
  - S_CMD: on a byte equal to CMD_WR go to S_AH. Any other byte: set spi_err and stay in S_CMD.
  - S_AH: latch addr[15:8], go to S_AL.
  - S_AL: latch addr[7:0], go to S_DT.
  - S_DT: latch data and complete the frame, go to S_CMD.
- Timeout:
  - The timer clears on every counted byte and on entry to S_CMD.
  - It increments each cycle while in S_AH, S_AL or S_DT.
  - When the timer reaches TMO_CYC-1 with no byte in that cycle: set spi_err, go to S_CMD, discard the partial frame.
  - A byte arriving in the same cycle as the timeout wins; the timer clears and there is no error.
- Frame completion:
  - The frame is accepted when pend=0, or when pend=1 and the buffer is draining in that same cycle.
  - On accept: buffer={addr,data}, pend=1, frm_cnt+=1 (wraps 255->0).
  - Otherwise the frame is dropped and spi_ovf is set. The buffer and frm_cnt are unchanged.
- Write arbitration (registered outputs, 1-cycle latency):
  - Cycle t, fx_wr=1: at t+1, reg_wr=1 with fx_waddr/fx_data. A pending SPI write waits.
  - Cycle t, fx_wr=0 and pend=1: at t+1, reg_wr=1 with buffer contents; pend clears.
  - Neither: reg_wr=0; reg_waddr and reg_data hold their last values.
  - Host writes are never stalled or dropped. The system contract guarantees fx_wr is sporadic, so SPI writes cannot starve indefinitely.
- spi_busy = (state != S_CMD) | pend.
- Sticky flags:
  - stat_clr=1 clears spi_err and spi_ovf.
  - A set event and stat_clr in the same cycle leave the flag set.

Test Plan:
- Bytes A5,12,34,5C with gaps of 3 cycles, mcu_sel=1, no fx_wr -> single reg_wr pulse one cycle after the last spi_vld, reg_waddr=16'h1234, reg_data=8'h5C; frm_cnt=1; spi_busy=0 afterwards.
- fx_wr=1 (addr 16'h0040, data 8'h11) held for 3 cycles, overlapping completion of SPI frame A5,00,80,22 -> three host writes to 0040 appear first; the SPI write to 0080/22 appears in the cycle after fx_wr drops.
- With TMO_CYC=16: send A5,12, then idle 20 cycles -> spi_err=1 at cycle 15 after the 12 byte, FSM back to S_CMD, no reg_wr; the following frame A5,00,01,FF writes normally.
- Byte 3C in S_CMD -> spi_err=1, no state change; stat_clr pulse -> spi_err=0; with stat_clr and a bad byte in the same cycle, spi_err=1.
- fx_wr held high continuously while two full SPI frames complete -> the first is buffered, the second is dropped; spi_ovf=1, frm_cnt=1; after fx_wr drops, only the first frame is written.
- Assert rst in S_AL mid-frame while pend=1 -> next cycle all outputs at reset values, no reg_wr; a subsequent clean frame writes correctly and frm_cnt=1.

Source files
------------

// File: rtl/ex_spi_arb_if.sv
// ex_spi_arb_if: bundles the SPI byte stream, host fx-bus, ex_reg port and
// status signals of ex_spi_arb.
//   slave  : view used by ex_spi_arb
//   master : view used by whoever drives the SPI/host side (and models ex_reg)
// Signal names match the flat ports of the original ex_spi_arb.
interface ex_spi_arb_if;
  // SPI deserializer side
  logic [7:0]  spi_data;
  logic        spi_vld;
  logic        mcu_sel;
  // host fx-bus
  logic [15:0] fx_waddr;
  logic        fx_wr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [15:0] fx_raddr;
  logic [7:0]  fx_q;
  // ex_reg port
  logic [15:0] reg_waddr;
  logic        reg_wr;
  logic [7:0]  reg_data;
  logic        reg_rd;
  logic [15:0] reg_raddr;
  logic [7:0]  reg_q;
  // status
  logic        stat_clr;
  logic        spi_busy;
  logic        spi_err;
  logic        spi_ovf;
  logic [7:0]  frm_cnt;

  modport slave (
    input  spi_data, spi_vld, mcu_sel,
    input  fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    output fx_q,
    output reg_waddr, reg_wr, reg_data, reg_rd, reg_raddr,
    input  reg_q,
    input  stat_clr,
    output spi_busy, spi_err, spi_ovf, frm_cnt
  );

  modport master (
    output spi_data, spi_vld, mcu_sel,
    output fx_waddr, fx_wr, fx_data, fx_rd, fx_raddr,
    input  fx_q,
    input  reg_waddr, reg_wr, reg_data, reg_rd, reg_raddr,
    output reg_q,
    output stat_clr,
    input  spi_busy, spi_err, spi_ovf, frm_cnt
  );
endinterface

// File: rtl/ex_spi_arb.sv
// ex_spi_arb: parses 4-byte MCU SPI write frames (CMD_WR, addr_hi, addr_lo,
// data) and merges them with host fx-bus writes onto the single ex_reg write
// port. Host writes always win; one completed SPI frame is held in a
// one-deep buffer until a host-free cycle. Reads pass straight through.
// Ports:
//   clk_sys : system clock
//   rst     : synchronous reset, active-high
//   bus     : ex_spi_arb_if.slave (SPI stream, fx-bus, ex_reg port, status)
module ex_spi_arb #(
  parameter int unsigned TMO_CYC = 1024,
  parameter logic [7:0]  CMD_WR  = 8'hA5
) (
  input  logic         clk_sys,
  input  logic         rst,
  ex_spi_arb_if.slave  bus
);

  localparam int unsigned TW = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  typedef enum logic [1:0] {S_CMD, S_AH, S_AL, S_DT} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   addr_q, addr_d;
  logic [23:0]   buf_q, buf_d;
  logic          pend_q, pend_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;
  logic          reg_wr_q, reg_wr_d;
  logic [15:0]   reg_waddr_q, reg_waddr_d;
  logic [7:0]    reg_data_q, reg_data_d;

  logic byte_ok;
  logic drain;
  logic frame_done;
  logic err_set;
  logic ovf_set;

  // Read path: no arbitration
  assign bus.reg_rd    = bus.fx_rd;
  assign bus.reg_raddr = bus.fx_raddr;
  assign bus.fx_q      = bus.reg_q;

  assign byte_ok = bus.spi_vld & bus.mcu_sel;
  // Buffer empties into ex_reg whenever the host is not writing
  assign drain   = pend_q & ~bus.fx_wr;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    addr_d      = addr_q;
    buf_d       = buf_q;
    pend_d      = pend_q;
    cnt_d       = cnt_q;
    frame_done  = 1'b0;
    err_set     = 1'b0;
    ovf_set     = 1'b0;
    reg_wr_d    = 1'b0;
    reg_waddr_d = reg_waddr_q;
    reg_data_d  = reg_data_q;

    // Parser and inter-byte timeout
    if (state_q == S_CMD) begin
      timer_d = '0;
      if (byte_ok) begin
        if (bus.spi_data == CMD_WR) begin
          state_d = S_AH;
        end else begin
          err_set = 1'b1;
        end
      end
    end else if (byte_ok) begin
      // A byte in the timeout cycle wins over the timeout
      timer_d = '0;
      case (state_q)
        S_AH: begin
          addr_d[15:8] = bus.spi_data;
          state_d      = S_AL;
        end
        S_AL: begin
          addr_d[7:0] = bus.spi_data;
          state_d     = S_DT;
        end
        default: begin
          frame_done = 1'b1;
          state_d    = S_CMD;
        end
      endcase
    end else if (timer_q == TMO_LAST) begin
      err_set = 1'b1;
      state_d = S_CMD;
      timer_d = '0;
    end else begin
      timer_d = timer_q + 1'b1;
    end

    // One-deep buffer: a slot frees up in the same cycle it drains
    if (drain) begin
      pend_d = 1'b0;
    end
    if (frame_done) begin
      if (!pend_q || drain) begin
        buf_d  = {addr_q, bus.spi_data};
        pend_d = 1'b1;
        cnt_d  = cnt_q + 8'd1;
      end else begin
        ovf_set = 1'b1;
      end
    end

    // Write arbitration, host first
    if (bus.fx_wr) begin
      reg_wr_d    = 1'b1;
      reg_waddr_d = bus.fx_waddr;
      reg_data_d  = bus.fx_data;
    end else if (pend_q) begin
      reg_wr_d    = 1'b1;
      reg_waddr_d = buf_q[23:8];
      reg_data_d  = buf_q[7:0];
    end

    // Sticky flags: a set event beats a simultaneous clear
    err_d = err_set | (err_q & ~bus.stat_clr);
    ovf_d = ovf_set | (ovf_q & ~bus.stat_clr);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= S_CMD;
      timer_q     <= '0;
      addr_q      <= '0;
      buf_q       <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      reg_wr_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      addr_q      <= addr_d;
      buf_q       <= buf_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      reg_wr_q    <= reg_wr_d;
      reg_waddr_q <= reg_waddr_d;
      reg_data_q  <= reg_data_d;
    end
  end

  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_waddr = reg_waddr_q;
  assign bus.reg_data  = reg_data_q;
  assign bus.spi_busy  = (state_q != S_CMD) | pend_q;
  assign bus.spi_err   = err_q;
  assign bus.spi_ovf   = ovf_q;
  assign bus.frm_cnt   = cnt_q;

endmodule

// File: tb/tb_ex_spi_arb.sv
module tb_ex_spi_arb;

  logic clk_sys = 1'b0;
  logic rst     = 1'b0;
  int   total   = 0;
  int   bad     = 0;
  int   wr_cnt  = 0;

  ex_spi_arb_if bus ();

  ex_spi_arb #(.TMO_CYC(16), .CMD_WR(8'hA5)) dut (
    .clk_sys (clk_sys),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick;
    @(posedge clk_sys);
    #1;
    if (bus.reg_wr === 1'b1) wr_cnt++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.spi_data = b;
    bus.spi_vld  = 1'b1;
    tick();
    bus.spi_vld  = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr_cnt = 0;
  endtask

  task automatic test_reset;
    // garbage on the inputs during reset must be ignored
    rst = 1'b1;
    bus.spi_data = 8'hA5; bus.spi_vld = 1'b1;
    bus.fx_wr = 1'b1; bus.fx_waddr = 16'hBEEF; bus.fx_data = 8'h99;
    tick(); tick();
    bus.spi_vld = 1'b0; bus.fx_wr = 1'b0;
    rst = 1'b0;
    total++; if (bus.reg_wr !== 1'b0) begin bad++; $display("FAIL rst_reg_wr got=%b exp=0", bus.reg_wr); end
    total++; if (bus.reg_waddr !== 16'h0000) begin bad++; $display("FAIL rst_reg_waddr got=%h exp=0000", bus.reg_waddr); end
    total++; if (bus.reg_data !== 8'h00) begin bad++; $display("FAIL rst_reg_data got=%h exp=00", bus.reg_data); end
    total++; if ({bus.spi_busy, bus.spi_err, bus.spi_ovf} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {bus.spi_busy, bus.spi_err, bus.spi_ovf}); end
    total++; if (bus.frm_cnt !== 8'd0) begin bad++; $display("FAIL rst_frm_cnt got=%0d exp=0", bus.frm_cnt); end
  endtask

  task automatic test_read_path;
    bus.fx_rd = 1'b1; bus.fx_raddr = 16'hC3A7; bus.reg_q = 8'h5E;
    #1;
    total++; if (bus.reg_rd !== 1'b1) begin bad++; $display("FAIL rd_strobe got=%b exp=1", bus.reg_rd); end
    total++; if (bus.reg_raddr !== 16'hC3A7) begin bad++; $display("FAIL rd_addr got=%h exp=c3a7", bus.reg_raddr); end
    total++; if (bus.fx_q !== 8'h5E) begin bad++; $display("FAIL rd_data got=%h exp=5e", bus.fx_q); end
    bus.fx_rd = 1'b0; bus.reg_q = 8'h21;
    #1;
    total++; if ({bus.reg_rd, bus.fx_q} !== {1'b0, 8'h21}) begin bad++; $display("FAIL rd_idle got=%b/%h exp=0/21", bus.reg_rd, bus.fx_q); end
    tick();
  endtask

  task automatic test_basic_frame;
    do_reset();
    send_byte(8'hA5); idle(3);
    // byte with mcu_sel low must be ignored
    bus.mcu_sel = 1'b0; send_byte(8'h77); bus.mcu_sel = 1'b1; idle(2);
    send_byte(8'h12); idle(3);
    send_byte(8'h34); idle(3);
    send_byte(8'h5C);
    total++; if ({bus.reg_wr, bus.spi_busy} !== 2'b01) begin bad++; $display("FAIL basic_pre got wr/busy=%b exp=01", {bus.reg_wr, bus.spi_busy}); end
    tick();
    total++; if (bus.reg_wr !== 1'b1) begin bad++; $display("FAIL basic_wr got=%b exp=1", bus.reg_wr); end
    total++; if (bus.reg_waddr !== 16'h1234) begin bad++; $display("FAIL basic_addr got=%h exp=1234", bus.reg_waddr); end
    total++; if (bus.reg_data !== 8'h5C) begin bad++; $display("FAIL basic_data got=%h exp=5c", bus.reg_data); end
    total++; if (bus.frm_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", bus.frm_cnt); end
    idle(3);
    total++; if (wr_cnt != 1) begin bad++; $display("FAIL basic_pulses got=%0d exp=1", wr_cnt); end
    total++; if ({bus.spi_busy, bus.spi_err} !== 2'b00) begin bad++; $display("FAIL basic_after got busy/err=%b exp=00", {bus.spi_busy, bus.spi_err}); end
    total++; if (bus.reg_waddr !== 16'h1234) begin bad++; $display("FAIL basic_hold got=%h exp=1234", bus.reg_waddr); end
  endtask

  task automatic test_host_priority;
    do_reset();
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h80);
    bus.fx_waddr = 16'h0040; bus.fx_data = 8'h11; bus.fx_wr = 1'b1;
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0040, 8'h11}) begin bad++; $display("FAIL prio_h1 got=%b/%h/%h exp=1/0040/11", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    send_byte(8'h22);
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0040, 8'h11}) begin bad++; $display("FAIL prio_h2 got=%b/%h/%h exp=1/0040/11", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0040, 8'h11}) begin bad++; $display("FAIL prio_h3 got=%b/%h/%h exp=1/0040/11", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    bus.fx_wr = 1'b0;
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0080, 8'h22}) begin bad++; $display("FAIL prio_spi got=%b/%h/%h exp=1/0080/22", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    tick();
    total++; if ({bus.reg_wr, bus.spi_busy} !== 2'b00) begin bad++; $display("FAIL prio_end got wr/busy=%b exp=00", {bus.reg_wr, bus.spi_busy}); end
    total++; if (wr_cnt != 4) begin bad++; $display("FAIL prio_pulses got=%0d exp=4", wr_cnt); end
  endtask

  task automatic test_timeout;
    do_reset();
    send_byte(8'hA5); send_byte(8'h12);
    // timer is 0 after the 12 byte and reaches 15 after 15 more edges
    idle(15);
    total++; if ({bus.spi_err, bus.spi_busy} !== 2'b01) begin bad++; $display("FAIL tmo_early got err/busy=%b exp=01", {bus.spi_err, bus.spi_busy}); end
    tick();
    total++; if ({bus.spi_err, bus.spi_busy} !== 2'b10) begin bad++; $display("FAIL tmo_fire got err/busy=%b exp=10", {bus.spi_err, bus.spi_busy}); end
    idle(4);
    total++; if (wr_cnt != 0) begin bad++; $display("FAIL tmo_nowr got=%0d exp=0", wr_cnt); end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0001, 8'hFF}) begin bad++; $display("FAIL tmo_next got=%b/%h/%h exp=1/0001/ff", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    total++; if (bus.frm_cnt !== 8'd1) begin bad++; $display("FAIL tmo_cnt got=%0d exp=1", bus.frm_cnt); end
  endtask

  task automatic test_bad_cmd;
    do_reset();
    send_byte(8'h3C);
    total++; if ({bus.spi_err, bus.spi_busy} !== 2'b10) begin bad++; $display("FAIL bad_cmd got err/busy=%b exp=10", {bus.spi_err, bus.spi_busy}); end
    bus.stat_clr = 1'b1; tick(); bus.stat_clr = 1'b0;
    total++; if (bus.spi_err !== 1'b0) begin bad++; $display("FAIL bad_clr got=%b exp=0", bus.spi_err); end
    bus.stat_clr = 1'b1; send_byte(8'h3C); bus.stat_clr = 1'b0;
    total++; if (bus.spi_err !== 1'b1) begin bad++; $display("FAIL bad_setclr got=%b exp=1", bus.spi_err); end
    tick();
    total++; if (bus.spi_err !== 1'b1) begin bad++; $display("FAIL bad_sticky got=%b exp=1", bus.spi_err); end
  endtask

  task automatic test_overflow;
    do_reset();
    bus.fx_waddr = 16'h0200; bus.fx_data = 8'h77; bus.fx_wr = 1'b1;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00); send_byte(8'hAA);
    total++; if (bus.spi_ovf !== 1'b0) begin bad++; $display("FAIL ovf_first got=%b exp=0", bus.spi_ovf); end
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01); send_byte(8'hBB);
    total++; if (bus.spi_ovf !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.spi_ovf); end
    total++; if (bus.frm_cnt !== 8'd1) begin bad++; $display("FAIL ovf_cnt got=%0d exp=1", bus.frm_cnt); end
    total++; if ({bus.reg_waddr, bus.reg_data} !== {16'h0200, 8'h77}) begin bad++; $display("FAIL ovf_host got=%h/%h exp=0200/77", bus.reg_waddr, bus.reg_data); end
    bus.fx_wr = 1'b0;
    wr_cnt = 0;
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0100, 8'hAA}) begin bad++; $display("FAIL ovf_drain got=%b/%h/%h exp=1/0100/aa", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    idle(4);
    total++; if (wr_cnt != 1) begin bad++; $display("FAIL ovf_only1 got=%0d exp=1", wr_cnt); end
    bus.stat_clr = 1'b1; tick(); bus.stat_clr = 1'b0;
    total++; if (bus.spi_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.spi_ovf); end
  endtask

  task automatic test_reset_midframe;
    do_reset();
    bus.fx_waddr = 16'h0300; bus.fx_data = 8'h33; bus.fx_wr = 1'b1;
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00); send_byte(8'h44);
    send_byte(8'hA5); send_byte(8'h05);
    total++; if ({bus.spi_busy, bus.frm_cnt} !== {1'b1, 8'd1}) begin bad++; $display("FAIL mid_pre got busy/cnt=%b/%0d exp=1/1", bus.spi_busy, bus.frm_cnt); end
    rst = 1'b1; bus.fx_wr = 1'b0;
    tick();
    rst = 1'b0;
    wr_cnt = 0;
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b0, 16'h0000, 8'h00}) begin bad++; $display("FAIL mid_out got=%b/%h/%h exp=0/0000/00", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    total++; if ({bus.spi_busy, bus.spi_err, bus.spi_ovf, bus.frm_cnt} !== {3'b000, 8'd0}) begin bad++; $display("FAIL mid_stat got=%b/%0d exp=000/0", {bus.spi_busy, bus.spi_err, bus.spi_ovf}, bus.frm_cnt); end
    idle(3);
    total++; if (wr_cnt != 0) begin bad++; $display("FAIL mid_nowr got=%0d exp=0", wr_cnt); end
    send_byte(8'hA5); send_byte(8'h06); send_byte(8'h00); send_byte(8'h66);
    tick();
    total++; if ({bus.reg_wr, bus.reg_waddr, bus.reg_data} !== {1'b1, 16'h0600, 8'h66}) begin bad++; $display("FAIL mid_frame got=%b/%h/%h exp=1/0600/66", bus.reg_wr, bus.reg_waddr, bus.reg_data); end
    total++; if (bus.frm_cnt !== 8'd1) begin bad++; $display("FAIL mid_cnt got=%0d exp=1", bus.frm_cnt); end
  endtask

  initial begin
    bus.spi_data = '0; bus.spi_vld = 1'b0; bus.mcu_sel = 1'b1;
    bus.fx_waddr = '0; bus.fx_wr = 1'b0; bus.fx_data = '0;
    bus.fx_rd = 1'b0; bus.fx_raddr = '0; bus.reg_q = '0;
    bus.stat_clr = 1'b0;
    test_reset();
    test_read_path();
    test_basic_frame();
    test_host_priority();
    test_timeout();
    test_bad_cmd();
    test_overflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
